sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl_pkg.sv | 23 ++
 rtl/sram_wait_cnt.sv | 27 ++
 rtl/sram_ctrl.sv | 116 +++++++++++
 tb/tb_sram_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 32-bit to 16-bit SRAM access controller.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned SRAM_ADDR_W   = 18;
    localparam int unsigned SRAM_DATA_W   = 16;
    localparam int unsigned WORD_W        = SRAM_ADDR_W - 1;
    localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;

    // Byte offsets are dropped before subtracting so address[1:0] never matter;
    // the cast keeps the modulo-2^17 wrap for addresses below the base.
    function automatic logic [WORD_W-1:0] word_idx(input logic [31:0] addr,
                                                   input logic [31:0] base);
        return WORD_W'((addr >> 2) - (base >> 2));
    endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Phase-length down-counter: reloads at the start of each half-word phase and
// reports done on the phase's final cycle.
module sram_wait_cnt #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic done_o
);
    localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= CW'(WAIT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Splits 32-bit loads/stores into two 16-bit SRAM accesses (low half first).
// Define SRAM_CTRL_WAIT_EN to stretch each half-word phase to WAIT_CYCLES+1 cycles.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);

    state_t                 state_q;
    logic                   is_wr_q;
    logic [WORD_W-1:0]      word_q;
    logic [SRAM_DATA_W-1:0] wdata_hi_q;
    logic [31:0]            rdata_q;
    logic [SRAM_ADDR_W-1:0] addr_q;
    logic [SRAM_DATA_W-1:0] dq_out_q;
    logic                   oe_q;
    logic                   we_n_q;

    logic                   req;
    logic                   phase_done;
    logic [WORD_W-1:0]      req_word;

    assign req      = wr_en | rd_en;
    assign req_word = word_idx(address, BASE_ADDR);

`ifdef SRAM_CTRL_WAIT_EN
    logic cnt_load;

    // Reload on entry to LO and again on entry to HI.
    assign cnt_load = ((state_q == IDLE) && req) || ((state_q == LO) && phase_done);

    sram_wait_cnt #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (cnt_load),
        .done_o (phase_done)
    );
`else
    assign phase_done = 1'b1;
`endif

    // SRAM pins are registered: each is set on the edge entering the phase it belongs to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            is_wr_q    <= 1'b0;
            word_q     <= '0;
            wdata_hi_q <= '0;
            rdata_q    <= '0;
            addr_q     <= '0;
            dq_out_q   <= '0;
            oe_q       <= 1'b0;
            we_n_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q    <= LO;
                        is_wr_q    <= wr_en;
                        word_q     <= req_word;
                        wdata_hi_q <= write_data[31:16];
                        addr_q     <= {req_word, 1'b0};
                        dq_out_q   <= wr_en ? write_data[15:0] : '0;
                        oe_q       <= wr_en;
                        we_n_q     <= !wr_en;
                    end
                end
                LO: begin
                    if (phase_done) begin
                        if (!is_wr_q) rdata_q[15:0] <= sram_dq_in;
                        state_q  <= HI;
                        addr_q   <= {word_q, 1'b1};
                        dq_out_q <= is_wr_q ? wdata_hi_q : '0;
                    end
                end
                HI: begin
                    if (phase_done) begin
                        if (!is_wr_q) rdata_q[31:16] <= sram_dq_in;
                        state_q  <= DONE;
                        addr_q   <= '0;
                        dq_out_q <= '0;
                        oe_q     <= 1'b0;
                        we_n_q   <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready       = (state_q == DONE) || ((state_q == IDLE) && !req);
    assign read_data   = rdata_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = oe_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed table-driven bench for sram_ctrl; phase length follows SRAM_CTRL_WAIT_EN.
module tb_sram_ctrl;

    localparam int unsigned WAIT_CYCLES = 2;
`ifdef SRAM_CTRL_WAIT_EN
    localparam int PH = WAIT_CYCLES + 1;
`else
    localparam int PH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;
    logic [15:0] drv_lo, drv_hi;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // SRAM stand-in: returns the low or high half chosen by the half-word bit.
    assign sram_dq_in = sram_addr[0] ? drv_hi : drv_lo;

    sram_ctrl #(
        .BASE_ADDR   (32'd1024),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] dlo;
        logic [15:0] dhi;
        logic [16:0] word;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic is_wr;
        is_wr      = v.wr;
        wr_en      = v.wr;
        rd_en      = v.rd;
        address    = v.addr;
        write_data = v.wdata;
        drv_lo     = v.dlo;
        drv_hi     = v.dhi;
        #1;
        chk("req_ready_low", 32'(ready), 32'(0));
        for (int p = 0; p < PH; p++) begin
            @(negedge clk);
            chk("lo_addr",  32'(sram_addr), 32'({v.word, 1'b0}));
            chk("lo_we_n",  32'(sram_we_n), 32'(!is_wr));
            chk("lo_oe",    32'(sram_dq_oe), 32'(is_wr));
            chk("lo_dq",    32'(sram_dq_out), is_wr ? 32'(v.wdata[15:0]) : 32'(0));
            chk("lo_ready", 32'(ready), 32'(0));
        end
        for (int p = 0; p < PH; p++) begin
            @(negedge clk);
            chk("hi_addr",  32'(sram_addr), 32'({v.word, 1'b1}));
            chk("hi_we_n",  32'(sram_we_n), 32'(!is_wr));
            chk("hi_oe",    32'(sram_dq_oe), 32'(is_wr));
            chk("hi_dq",    32'(sram_dq_out), is_wr ? 32'(v.wdata[31:16]) : 32'(0));
            chk("hi_ready", 32'(ready), 32'(0));
        end
        @(negedge clk);
        chk("done_ready", 32'(ready), 32'(1));
        chk("done_rdata", read_data, v.rdata);
        chk("done_addr",  32'(sram_addr), 32'(0));
        // Request still held through DONE: the controller must not restart from it.
        @(negedge clk);
        chk("post_addr", 32'(sram_addr), 32'(0));
        chk("post_we_n", 32'(sram_we_n), 32'(1));
        chk("post_oe",   32'(sram_dq_oe), 32'(0));
        wr_en = 1'b0;
        rd_en = 1'b0;
        #1;
        chk("idle_ready", 32'(ready), 32'(1));
    endtask

    initial begin
        //          wr    rd    addr           wdata          dlo       dhi       word       rdata
        vecs[0] = '{1'b1, 1'b0, 32'd1024,      32'hDEADBEEF, 16'h0000, 16'h0000, 17'h00000, 32'h00000000};
        vecs[1] = '{1'b0, 1'b1, 32'd1032,      32'h00000000, 16'h5678, 16'h1234, 17'h00002, 32'h12345678};
        vecs[2] = '{1'b1, 1'b1, 32'd1028,      32'hCAFEF00D, 16'h9999, 16'h7777, 17'h00001, 32'h12345678};
        vecs[3] = '{1'b0, 1'b1, 32'd1020,      32'h00000000, 16'h0001, 16'h8000, 17'h1FFFF, 32'h80000001};
        vecs[4] = '{1'b1, 1'b0, 32'd1023,      32'h01234567, 16'h0000, 16'h0000, 17'h1FFFF, 32'h80000001};
        vecs[5] = '{1'b0, 1'b1, 32'h0008_0400, 32'h00000000, 16'hAAAA, 16'h5555, 17'h00000, 32'h5555AAAA};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_2403, 32'h00000000, 16'hFFFF, 16'h0000, 17'h00800, 32'h0000FFFF};

        rst        = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        address    = '0;
        write_data = '0;
        drv_lo     = '0;
        drv_hi     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_ready", 32'(ready), 32'(1));
        chk("rst_we_n",  32'(sram_we_n), 32'(1));
        chk("rst_oe",    32'(sram_dq_oe), 32'(0));
        chk("rst_addr",  32'(sram_addr), 32'(0));
        chk("rst_dq",    32'(sram_dq_out), 32'(0));
        chk("rst_rdata", read_data, 32'(0));

        @(negedge clk);
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset asserted during the HI phase of a write.
        @(negedge clk);
        wr_en      = 1'b1;
        address    = 32'd1040;
        write_data = 32'h11112222;
        repeat (PH) @(negedge clk);
        @(negedge clk);
        chk("mid_hi_addr", 32'(sram_addr), 32'(9));
        chk("mid_hi_dq",   32'(sram_dq_out), 32'h1111);
        rst   = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_we_n",  32'(sram_we_n), 32'(1));
        chk("midrst_oe",    32'(sram_dq_oe), 32'(0));
        chk("midrst_addr",  32'(sram_addr), 32'(0));
        chk("midrst_dq",    32'(sram_dq_out), 32'(0));
        chk("midrst_ready", 32'(ready), 32'(1));
        chk("midrst_rdata", read_data, 32'(0));
        repeat (2) @(negedge clk);
        chk("noretry_we_n", 32'(sram_we_n), 32'(1));
        chk("noretry_addr", 32'(sram_addr), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
